// File: rtl/noc_pkg.sv
// Shared NoC definitions: packet type encoding, header field offsets, arbiter FSM states.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package noc_pkg;

  // Packet type lives in the top PACKET_TYPE_WIDTH bits of every header flit.
  localparam int PACKET_TYPE_WIDTH = 4;
  localparam logic [PACKET_TYPE_WIDTH-1:0] ROUTING_HEADER = 4'hA;

  typedef enum logic {
    IDLE   = 1'b0,
    PACKET = 1'b1
  } arb_state_t;

  // Header layout from bit 0 upward: y, x, src (x,y), len.
  function automatic int hdr_y_lsb();
    return 0;
  endfunction

  function automatic int hdr_x_lsb(input int yw);
    return yw;
  endfunction

  function automatic int hdr_src_lsb(input int xw, input int yw);
    return xw + yw;
  endfunction

  function automatic int hdr_len_lsb(input int xw, input int yw);
    return 2 * (xw + yw);
  endfunction

endpackage

// File: rtl/axis_if.sv
// AXI-Stream style flit link: TVALID/TREADY handshake, TDATA payload, TLAST marker.
// Latency: n/a (wires only).
// Backpressure: a transfer happens on a clock edge where TVALID and TREADY are both high.
interface axis_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  TVALID;
  logic                  TREADY;
  logic                  TLAST;
  logic [DATA_WIDTH-1:0] TDATA;

  modport m (output TVALID, output TDATA, output TLAST, input TREADY);
  modport s (input TVALID, input TDATA, input TLAST, output TREADY);
endinterface

// File: rtl/axis_packet_arbiter_rr_grant_picker.sv
// Round-robin picker: first requester strictly after last_grant, wrapping modulo CHANNEL_NUMBER.
// Latency: combinational.
// Backpressure: none; any_req low means no channel is requesting.
// Ports: req[CH] in, last_grant in, next_grant out, any_req out.
module rr_grant_picker #(
  parameter  int CHANNEL_NUMBER = 5,
  localparam int CNW            = $clog2(CHANNEL_NUMBER)
) (
  input  logic [CHANNEL_NUMBER-1:0] req,
  input  logic [CNW-1:0]            last_grant,
  output logic [CNW-1:0]            next_grant,
  output logic                      any_req
);

  always_comb begin
    int idx;
    idx        = 0;
    next_grant = '0;
    any_req    = 1'b0;
    // i runs 1..CH so last_grant itself is considered last; explicit wrap
    // keeps this correct for channel counts that are not powers of two.
    for (int i = 1; i <= CHANNEL_NUMBER; i++) begin
      idx = int'(last_grant) + i;
      if (idx >= CHANNEL_NUMBER) idx = idx - CHANNEL_NUMBER;
      if (!any_req && req[idx]) begin
        any_req    = 1'b1;
        next_grant = CNW'(idx);
      end
    end
  end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-locked round-robin merge of CHANNEL_NUMBER streams into one, through a 2-entry skid buffer.
// Latency: 1 bubble cycle to arbitrate, then 1 cycle from input handshake to out.TVALID.
// Backpressure: granted TREADY = skid buffer not full (registered); others held at 0.
// Ports: clk, rst_n (async low); in[CH] slave streams; out master stream;
//        target_x/target_y = sideband of the out head flit; grant = owning channel; busy = in PACKET.
// Option: define AXIS_ARB_TLAST_EN to end packets on input TLAST instead of the header length.
module axis_packet_arbiter
  import noc_pkg::*;
#(
  parameter  int DATA_WIDTH     = 32,
  parameter  int CHANNEL_NUMBER = 5,
  parameter  int MAX_ROUTERS_X  = 4,
  parameter  int MAX_ROUTERS_Y  = 4,
  parameter  int MAX_BODY_FLITS = 4,
  localparam int XW             = $clog2(MAX_ROUTERS_X),
  localparam int YW             = $clog2(MAX_ROUTERS_Y),
  localparam int LW             = $clog2(MAX_BODY_FLITS + 1),
  localparam int CNW            = $clog2(CHANNEL_NUMBER)
) (
  input  logic           clk,
  input  logic           rst_n,
  axis_if.s              in [CHANNEL_NUMBER],
  axis_if.m              out,
  output logic [XW-1:0]  target_x,
  output logic [YW-1:0]  target_y,
  output logic [CNW-1:0] grant,
  output logic           busy
);

  localparam int X_LSB   = hdr_x_lsb(YW);
  localparam int Y_LSB   = hdr_y_lsb();
  localparam int LEN_LSB = hdr_len_lsb(XW, YW);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] dat;
    logic [XW-1:0]         x;
    logic [YW-1:0]         y;
    logic                  last;
  } skid_ent_t;

  arb_state_t state, state_nxt;
  logic [CNW-1:0] last_grant, pick_grant;
  logic           pick_any;
  logic [LW-1:0]  remaining;
  logic           first_flit;
  logic [XW-1:0]  cur_x;
  logic [YW-1:0]  cur_y;
  logic           err_sticky;

  skid_ent_t ent0, ent1, push_ent;
  logic [1:0] count;
  logic       buf_full, pop;

  logic [CHANNEL_NUMBER-1:0] req_vld, ch_last;
  logic [DATA_WIDTH-1:0]     ch_dat [CHANNEL_NUMBER];

  logic                  sel_vld, sel_last, hs, is_hdr, flit_last;
  logic [DATA_WIDTH-1:0] sel_dat;
  logic [LW-1:0]         hdr_len;
  logic [XW-1:0]         hdr_x;
  logic [YW-1:0]         hdr_y;

  assign buf_full = (count == 2'd2);

  for (genvar i = 0; i < CHANNEL_NUMBER; i++) begin : g_ch
    assign req_vld[i] = in[i].TVALID;
    assign ch_dat[i]  = in[i].TDATA;
    assign ch_last[i] = in[i].TLAST;
    // Registered terms only, so TREADY never depends on any TVALID/TREADY combinationally.
    assign in[i].TREADY = (state == PACKET) && (grant == CNW'(i)) && !buf_full;
  end

  rr_grant_picker #(
    .CHANNEL_NUMBER(CHANNEL_NUMBER)
  ) u_picker (
    .req       (req_vld),
    .last_grant(last_grant),
    .next_grant(pick_grant),
    .any_req   (pick_any)
  );

  assign sel_vld  = req_vld[grant];
  assign sel_dat  = ch_dat[grant];
  assign sel_last = ch_last[grant];
  assign hs       = (state == PACKET) && sel_vld && !buf_full;

  assign is_hdr  = (sel_dat[DATA_WIDTH-1 -: PACKET_TYPE_WIDTH] == ROUTING_HEADER);
  assign hdr_len = sel_dat[LEN_LSB +: LW];
  assign hdr_x   = sel_dat[X_LSB +: XW];
  assign hdr_y   = sel_dat[Y_LSB +: YW];

  always_comb begin
    flit_last = 1'b0;
`ifdef AXIS_ARB_TLAST_EN
    if (first_flit && !is_hdr) flit_last = 1'b1;
    else                       flit_last = sel_last;
`else
    // A malformed first flit is forwarded alone so the port is never locked by garbage.
    if (first_flit) flit_last = is_hdr ? (hdr_len == '0) : 1'b1;
    else            flit_last = (remaining == LW'(1));
`endif
  end

  // The header carries its own coordinates; later flits reuse the latched ones.
  always_comb begin
    push_ent      = '0;
    push_ent.dat  = sel_dat;
    push_ent.x    = (first_flit && is_hdr) ? hdr_x : cur_x;
    push_ent.y    = (first_flit && is_hdr) ? hdr_y : cur_y;
    push_ent.last = flit_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_any) state_nxt = PACKET;
      PACKET:  if (hs && flit_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant      <= '0;
      last_grant <= CNW'(CHANNEL_NUMBER - 1);
      remaining  <= '0;
      first_flit <= 1'b1;
      cur_x      <= '0;
      cur_y      <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (state == IDLE && pick_any) begin
        grant      <= pick_grant;
        first_flit <= 1'b1;
      end
      if (hs) begin
        first_flit <= 1'b0;
        if (first_flit) begin
          if (is_hdr) begin
            remaining <= hdr_len;
            cur_x     <= hdr_x;
            cur_y     <= hdr_y;
          end else begin
            err_sticky <= 1'b1;
          end
        end else begin
          remaining <= remaining - LW'(1);
        end
        if (flit_last) last_grant <= grant;
      end
    end
  end

  // Skid buffer: ent0 is the head. It only shifts when a second entry exists,
  // so the head sideband holds its value once the buffer drains.
  assign pop = (count != 2'd0) && out.TREADY;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0  <= '0;
      ent1  <= '0;
      count <= 2'd0;
    end else begin
      case ({hs, pop})
        2'b10: begin
          if (count == 2'd0) ent0 <= push_ent;
          else               ent1 <= push_ent;
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) ent0 <= ent1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd2) begin
            ent0 <= ent1;
            ent1 <= push_ent;
          end else begin
            ent0 <= push_ent;
          end
        end
        default: ;
      endcase
    end
  end

  assign out.TVALID = (count != 2'd0);
  assign out.TDATA  = ent0.dat;
  assign out.TLAST  = ent0.last;
  assign target_x   = ent0.x;
  assign target_y   = ent0.y;
  assign busy       = (state == PACKET);

  // Debug-only state and the length-mode TLAST inputs, kept for hierarchical probing.
  logic unused_dbg;
  assign unused_dbg = err_sticky ^ (^ch_last);

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed bench for axis_packet_arbiter: per-channel flit queues, output monitor, scoreboard checks.
// Latency: n/a.
// Backpressure: output TREADY pattern selected per test (always, 1010 toggle, never).
module tb_axis_packet_arbiter;
  localparam int CH = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axis_if #(.DATA_WIDTH(32)) in_if [CH] ();
  axis_if #(.DATA_WIDTH(32)) out_if ();

  logic [1:0] target_x, target_y;
  logic [2:0] grant;
  logic       busy;

  axis_packet_arbiter dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in      (in_if),
    .out     (out_if),
    .target_x(target_x),
    .target_y(target_y),
    .grant   (grant),
    .busy    (busy)
  );

  logic [CH-1:0] tv, tl, tr, hs_next;
  logic [31:0]   td [CH];
  logic          out_rdy;

  for (genvar i = 0; i < CH; i++) begin : g_drv
    assign in_if[i].TVALID = tv[i];
    assign in_if[i].TDATA  = td[i];
    assign in_if[i].TLAST  = tl[i];
    assign tr[i]           = in_if[i].TREADY;
  end
  assign out_if.TREADY = out_rdy;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int cyc = 0, rdy_mode = 0, stall_viol = 0;
  logic        prev_stall;
  logic [31:0] prev_dat;

  logic [32:0] inq [CH][$];
  logic [31:0] obs_dat [$];
  logic        obs_last[$];
  logic [1:0]  obs_x[$], obs_y[$];
  int          obs_cyc[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] hdr(input int src, input int x, input int y, input int len);
    logic [31:0] h;
    h        = '0;
    h[31:28] = 4'hA;
    h[10:8]  = len[2:0];
    h[7:4]   = src[3:0];
    h[3:2]   = x[1:0];
    h[1:0]   = y[1:0];
    return h;
  endfunction

  function automatic logic [31:0] body(input int ch, input int k);
    return 32'h5000_0000 | (ch << 8) | k;
  endfunction

  task automatic push_pkt(input int ch, input int x, input int y, input int len);
    inq[ch].push_back({hdr(ch, x, y, len), (len == 0)});
    for (int k = 1; k <= len; k++) inq[ch].push_back({body(ch, k), (k == len)});
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_tb();
    for (int i = 0; i < CH; i++) inq[i].delete();
    obs_dat.delete(); obs_last.delete(); obs_x.delete(); obs_y.delete(); obs_cyc.delete();
    stall_viol = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_tb();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_obs(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (obs_dat.size() < n && k < budget) begin
      tick();
      k++;
    end
    repeat (6) tick();
    chk({tag, "_count"}, obs_dat.size(), n);
  endtask

  // Inputs and output monitor act on the falling edge, half a cycle from the DUT's edge.
  initial begin
    tv = '0; tl = '0; hs_next = '0; out_rdy = 1'b1; prev_stall = 1'b0; prev_dat = '0;
    for (int i = 0; i < CH; i++) td[i] = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        hs_next    = '0;
        prev_stall = 1'b0;
      end
      for (int i = 0; i < CH; i++)
        if (hs_next[i] && inq[i].size() != 0) void'(inq[i].pop_front());
      for (int i = 0; i < CH; i++) begin
        if (inq[i].size() != 0) begin
          {td[i], tl[i]} = inq[i][0];
          tv[i] = 1'b1;
        end else begin
          td[i] = '0; tl[i] = 1'b0; tv[i] = 1'b0;
        end
      end
      hs_next = tv & tr;
      out_rdy = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? cyc[0] : 1'b0;
      if (rst_n) begin
        if (prev_stall && (!out_if.TVALID || out_if.TDATA !== prev_dat)) stall_viol++;
        if (out_if.TVALID && out_rdy) begin
          obs_dat.push_back(out_if.TDATA);
          obs_last.push_back(out_if.TLAST);
          obs_x.push_back(target_x);
          obs_y.push_back(target_y);
          obs_cyc.push_back(cyc);
        end
        prev_stall = out_if.TVALID && !out_rdy;
        prev_dat   = out_if.TDATA;
      end
    end
  end

  initial begin
    int e_ch[4];
    int e_x[4];
    int e_y[4];
    int k;

    repeat (2) tick();
    chk("rst_tvalid", out_if.TVALID, 1'b0);
    chk("rst_tdata", out_if.TDATA, 32'h0);
    chk("rst_target_x", target_x, 2'd0);
    chk("rst_target_y", target_y, 2'd0);
    chk("rst_grant", grant, 3'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tready", tr, 5'b0);
    rst_n = 1'b1;
    tick();

    // 1: single 4-flit packet on ch2, back-to-back output.
    push_pkt(2, 2, 1, 3);
    wait_obs(4, 40, "t1");
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_dat%0d", i), obs_dat[i], (i == 0) ? hdr(2, 2, 1, 3) : body(2, i));
      chk($sformatf("t1_last%0d", i), obs_last[i], (i == 3));
      chk($sformatf("t1_x%0d", i), obs_x[i], 2'd2);
      chk($sformatf("t1_y%0d", i), obs_y[i], 2'd1);
      chk($sformatf("t1_cyc%0d", i), obs_cyc[i] - obs_cyc[0], i);
    end
    chk("t1_grant", grant, 3'd2);
    chk("t1_busy", busy, 1'b0);

    // 2: ch0 (two packets), ch1, ch4 contend; order 0,1,4,0 with one bubble each.
    do_reset();
    e_ch = '{0, 1, 4, 0};
    e_x  = '{1, 0, 2, 3};
    e_y  = '{0, 2, 3, 3};
    for (int p = 0; p < 4; p++) push_pkt(e_ch[p], e_x[p], e_y[p], 1);
    wait_obs(8, 60, "t2");
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("t2_hdr%0d", p), obs_dat[2*p], hdr(e_ch[p], e_x[p], e_y[p], 1));
      chk($sformatf("t2_body%0d", p), obs_dat[2*p+1], body(e_ch[p], 1));
      chk($sformatf("t2_tlast%0d", p), obs_last[2*p+1], 1'b1);
      chk($sformatf("t2_bodyx%0d", p), obs_x[2*p+1], e_x[p]);
      if (p < 3) chk($sformatf("t2_gap%0d", p), obs_cyc[2*p+2] - obs_cyc[2*p+1], 2);
    end

    // 3: ch4 owns the port, then ch0 and ch3 request; wrap makes ch0 next.
    do_reset();
    push_pkt(4, 1, 1, 1);
    k = 0;
    while (!(busy && grant == 3'd4) && k < 20) begin
      tick();
      k++;
    end
    chk("t3_grant4", grant, 3'd4);
    push_pkt(0, 0, 0, 1);
    push_pkt(3, 3, 0, 1);
    wait_obs(6, 60, "t3");
    chk("t3_first", obs_dat[0], hdr(4, 1, 1, 1));
    chk("t3_wrap", obs_dat[2], hdr(0, 0, 0, 1));
    chk("t3_third", obs_dat[4], hdr(3, 3, 0, 1));
    chk("t3_grant_end", grant, 3'd3);

    // 4: out.TREADY toggling during a 5-flit packet.
    do_reset();
    rdy_mode = 1;
    push_pkt(3, 1, 2, 4);
    wait_obs(5, 80, "t4");
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t4_dat%0d", i), obs_dat[i], (i == 0) ? hdr(3, 1, 2, 4) : body(3, i));
      chk($sformatf("t4_last%0d", i), obs_last[i], (i == 4));
    end
    chk("t4_stall_stable", stall_viol, 0);
    rdy_mode = 0;

    // 5: len=0 header on ch1 with ch3 waiting.
    do_reset();
    push_pkt(1, 2, 2, 0);
    push_pkt(3, 1, 3, 1);
    wait_obs(3, 40, "t5");
    chk("t5_hdr1", obs_dat[0], hdr(1, 2, 2, 0));
    chk("t5_last1", obs_last[0], 1'b1);
    chk("t5_hdr3", obs_dat[1], hdr(3, 1, 3, 1));
    chk("t5_hdr3_last", obs_last[1], 1'b0);
    chk("t5_gap", obs_cyc[1] - obs_cyc[0], 2);
    chk("t5_hold_x", target_x, 2'd1);
    chk("t5_hold_y", target_y, 2'd3);

    // 7: first flit is not a routing header -> forwarded alone, then ch1 rearbitrates.
    do_reset();
    inq[1].push_back({32'h0000_1234, 1'b1});
    push_pkt(1, 1, 1, 0);
    wait_obs(2, 40, "t7");
    chk("t7_bad_dat", obs_dat[0], 32'h0000_1234);
    chk("t7_bad_last", obs_last[0], 1'b1);
    chk("t7_next_hdr", obs_dat[1], hdr(1, 1, 1, 0));

    // 6: reset while the skid buffer holds two flits.
    do_reset();
    rdy_mode = 2;
    push_pkt(2, 3, 1, 3);
    repeat (8) tick();
    chk("t6_vld_before", out_if.TVALID, 1'b1);
    chk("t6_tready_full", tr[2], 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t6_vld_async", out_if.TVALID, 1'b0);
    chk("t6_busy_async", busy, 1'b0);
    clear_tb();
    repeat (3) tick();
    rdy_mode = 0;
    rst_n = 1'b1;
    tick();
    push_pkt(3, 0, 1, 1);
    push_pkt(0, 2, 0, 1);
    wait_obs(4, 40, "t6");
    chk("t6_ch0_first", obs_dat[0], hdr(0, 2, 0, 1));
    chk("t6_ch3_second", obs_dat[2], hdr(3, 0, 1, 1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
